// File: rtl/riscv_program_loader.sv
// riscv_program_loader: boot loader that streams a program image into instruction memory
//   and holds RISC_V_Core in reset until the image is loaded and its checksum matches.
// Ports:
//   clock, reset     single clock; asynchronous active-high reset
//   load_req         1-cycle request to begin a load (ignored while busy)
//   rx_data/rx_valid/rx_ready   byte stream; a byte moves when rx_valid & rx_ready
//   mem_write/mem_address/mem_data   one-cycle instruction-memory word write
//   core_reset/start/prog_address    core control: reset hold, start pulse, entry address
//   busy/done/error  load status
//   words_loaded     words written during the current load
// Image format (little-endian): LEN (word count N), N words, CSUM = XOR of all words.
module riscv_program_loader #(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDRESS = '0,
    parameter int                      MAX_WORDS    = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_req,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    core_reset,
    output logic                    start,
    output logic [ADDRESS_BITS-1:0] prog_address,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             words_loaded
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] START = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;

    logic [2:0]  state;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [31:0] len;
    logic [31:0] csum;
    logic [31:0] full_word;
    logic        take;
    logic        last_byte;

    // The first three bytes of a field sit in shift; the fourth completes it on the fly,
    // so a whole field is usable in the same cycle its last byte is transferred.
    assign full_word = {rx_data, shift};
    assign take      = rx_valid & rx_ready;
    assign last_byte = take & (byte_cnt == 2'd3);

    // Status and core control decode straight from state so an asynchronous reset
    // takes effect on the outputs immediately.
    assign rx_ready     = (state == LEN) || (state == DATA) || (state == CHECK);
    assign busy         = rx_ready || (state == START);
    assign start        = state == START;
    assign done         = state == DONE;
    assign error        = state == ERROR;
    assign core_reset   = !((state == START) || (state == DONE));
    assign prog_address = BASE_ADDRESS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            shift        <= 24'd0;
            len          <= 32'd0;
            csum         <= 32'd0;
            words_loaded <= 32'd0;
            mem_write    <= 1'b0;
            mem_address  <= BASE_ADDRESS;
            mem_data     <= '0;
        end else begin
            mem_write <= 1'b0;
            if (take) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {rx_data, shift[23:8]};
            end
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_req) begin
                        state        <= LEN;
                        byte_cnt     <= 2'd0;
                        csum         <= 32'd0;
                        words_loaded <= 32'd0;
                    end
                end
                LEN: begin
                    if (last_byte) begin
                        len   <= full_word;
                        state <= (full_word == 32'd0 || full_word > 32'(MAX_WORDS)) ? ERROR : DATA;
                    end
                end
                DATA: begin
                    if (last_byte) begin
                        mem_write    <= 1'b1;
                        mem_address  <= BASE_ADDRESS + words_loaded[ADDRESS_BITS-1:0];
                        mem_data     <= DATA_WIDTH'(full_word);
                        csum         <= csum ^ full_word;
                        words_loaded <= words_loaded + 32'd1;
                        // Moving to CHECK here makes bytes arriving during the final
                        // write cycle count as checksum bytes.
                        if (words_loaded + 32'd1 == len)
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    if (last_byte)
                        state <= (full_word == csum) ? START : ERROR;
                end
                START:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_program_loader.sv
// tb_riscv_program_loader: self-checking bench for riscv_program_loader with two
//   instances (base 0 and base 0xFFFFF) fed the same byte stream.
module tb_riscv_program_loader;
    localparam int AB = 20;
    localparam logic [AB-1:0] B1 = 20'hFFFFF;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready0, mem_write0, core_reset0, start0, busy0, done0, error0;
    logic          rx_ready1, mem_write1, core_reset1, start1, busy1, done1, error1;
    logic [AB-1:0] mem_address0, prog_address0, mem_address1, prog_address1;
    logic [31:0]   mem_data0, words_loaded0, mem_data1, words_loaded1;

    riscv_program_loader u0 (
        .clock(clock), .reset(reset), .load_req(load_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready0), .mem_write(mem_write0),
        .mem_address(mem_address0), .mem_data(mem_data0), .core_reset(core_reset0),
        .start(start0), .prog_address(prog_address0), .busy(busy0), .done(done0),
        .error(error0), .words_loaded(words_loaded0)
    );

    riscv_program_loader #(.BASE_ADDRESS(B1)) u1 (
        .clock(clock), .reset(reset), .load_req(load_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready1), .mem_write(mem_write1),
        .mem_address(mem_address1), .mem_data(mem_data1), .core_reset(core_reset1),
        .start(start1), .prog_address(prog_address1), .busy(busy1), .done(done1),
        .error(error1), .words_loaded(words_loaded1)
    );

    always #5 clock = ~clock;

    logic [AB-1:0] wa0[$], wa1[$];
    logic [31:0]   wd0[$], wd1[$];
    int            starts0 = 0, starts1 = 0, start_bad = 0;

    always @(negedge clock) begin
        if (mem_write0) begin
            wa0.push_back(mem_address0);
            wd0.push_back(mem_data0);
        end
        if (mem_write1) begin
            wa1.push_back(mem_address1);
            wd1.push_back(mem_data1);
        end
        if (start0) begin
            starts0++;
            if (core_reset0) start_bad++;
        end
        if (start1) begin
            starts1++;
            if (core_reset1) start_bad++;
        end
    end

    int          total = 0, bad = 0;
    logic [31:0] words[$];
    logic [7:0]  img[$];

    typedef struct {
        logic [31:0] len;
        bit          fixed;
        logic [31:0] csum_flip;
        int          gap;
        bit          exp_err;
        int          exp_wl;
    } vec_t;

    vec_t tv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit len_ok(input logic [31:0] n);
        return n != 32'd0 && n <= 32'd1024;
    endfunction

    function automatic logic [31:0] xor_all();
        logic [31:0] x = 32'd0;
        foreach (words[i]) x ^= words[i];
        return x;
    endfunction

    task automatic push32(input logic [31:0] w);
        for (int k = 0; k < 4; k++) img.push_back(w[8*k +: 8]);
    endtask

    task automatic pulse_load();
        @(posedge clock);
        #1 load_req = 1'b1;
        @(posedge clock);
        #1 load_req = 1'b0;
    endtask

    // Offers img byte by byte; a byte advances only when the DUT is ready at the edge.
    task automatic send(input int gap, input string tag);
        int i = 0;
        int cyc = 0;
        int budget = img.size() * 20 + 50;
        while (i < img.size() && cyc < budget) begin
            if ($urandom_range(99) < gap) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = img[i];
            end
            @(negedge clock);
            if (rx_valid && rx_ready0) i++;
            @(posedge clock);
            #1;
            cyc++;
        end
        rx_valid = 1'b0;
        check($sformatf("%s bytes_taken", tag), 32'(i), 32'(img.size()));
    endtask

    task automatic run_load(input logic [31:0] len_f, input logic [31:0] csum_f, input int gap,
                            input bit exp_err, input int exp_wl, input string tag);
        int b0, b1, s0, s1, sb, m0, m1;
        img.delete();
        push32(len_f);
        if (len_ok(len_f)) begin
            foreach (words[i]) push32(words[i]);
            push32(csum_f);
        end
        b0 = wa0.size();
        b1 = wa1.size();
        s0 = starts0;
        s1 = starts1;
        sb = start_bad;
        pulse_load();
        send(gap, tag);
        repeat (6) @(posedge clock);
        @(negedge clock);
        check($sformatf("%s error0", tag), 32'(error0), 32'(exp_err));
        check($sformatf("%s done0", tag), 32'(done0), 32'(!exp_err));
        check($sformatf("%s busy0", tag), 32'(busy0), 32'd0);
        check($sformatf("%s rx_ready0", tag), 32'(rx_ready0), 32'd0);
        check($sformatf("%s core_reset0", tag), 32'(core_reset0), 32'(exp_err));
        check($sformatf("%s words_loaded0", tag), words_loaded0, 32'(exp_wl));
        check($sformatf("%s start_pulses0", tag), 32'(starts0 - s0), 32'(!exp_err));
        check($sformatf("%s start_in_reset", tag), 32'(start_bad - sb), 32'd0);
        check($sformatf("%s error1", tag), 32'(error1), 32'(exp_err));
        check($sformatf("%s words_loaded1", tag), words_loaded1, 32'(exp_wl));
        check($sformatf("%s start_pulses1", tag), 32'(starts1 - s1), 32'(!exp_err));
        check($sformatf("%s nwrites0", tag), 32'(wa0.size() - b0), 32'(exp_wl));
        check($sformatf("%s nwrites1", tag), 32'(wa1.size() - b1), 32'(exp_wl));
        m0 = 0;
        m1 = 0;
        if (wa0.size() - b0 == exp_wl && wa1.size() - b1 == exp_wl && words.size() >= exp_wl) begin
            for (int i = 0; i < exp_wl; i++) begin
                if (wa0[b0+i] !== AB'(i) || wd0[b0+i] !== words[i]) m0++;
                if (wa1[b1+i] !== B1 + AB'(i) || wd1[b1+i] !== words[i]) m1++;
            end
        end else begin
            m0 = 1;
            m1 = 1;
        end
        check($sformatf("%s write_seq0", tag), 32'(m0), 32'd0);
        check($sformatf("%s write_seq1", tag), 32'(m1), 32'd0);
    endtask

    task automatic case1_words();
        words.delete();
        words.push_back(32'h00000013);
        words.push_back(32'h00100093);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{32'd2,    1'b1, 32'h0,          0,  1'b0, 2};
        tv[1] = '{32'd2,    1'b1, 32'h00100080,   0,  1'b1, 2};
        tv[2] = '{32'd0,    1'b0, 32'h0,          0,  1'b1, 0};
        tv[3] = '{32'd1025, 1'b0, 32'h0,          0,  1'b1, 0};
        tv[4] = '{32'd2,    1'b1, 32'h0,          50, 1'b0, 2};
        tv[5] = '{32'd1,    1'b0, 32'h0,          20, 1'b0, 1};
        tv[6] = '{32'd1024, 1'b0, 32'h0,          0,  1'b0, 1024};
        tv[7] = '{32'd3,    1'b0, 32'h80000000,   30, 1'b1, 3};

        repeat (2) @(negedge clock);
        check("rst core_reset0", 32'(core_reset0), 32'd1);
        check("rst busy0", 32'(busy0), 32'd0);
        check("rst rx_ready0", 32'(rx_ready0), 32'd0);
        check("rst start0", 32'(start0), 32'd0);
        check("rst done_error0", 32'({done0, error0}), 32'd0);
        check("rst mem_write0", 32'(mem_write0), 32'd0);
        check("rst prog_address0", 32'(prog_address0), 32'd0);
        check("rst prog_address1", 32'(prog_address1), 32'(B1));
        check("rst mem_address1", 32'(mem_address1), 32'(B1));
        check("rst words_loaded0", words_loaded0, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Bytes offered in IDLE must be left alone; a later load still parses LEN correctly.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (4) begin
            @(negedge clock);
            check("idle rx_ready0", 32'(rx_ready0), 32'd0);
        end
        @(posedge clock);
        #1;

        foreach (tv[k]) begin
            if (tv[k].fixed) begin
                case1_words();
            end else begin
                words.delete();
                if (len_ok(tv[k].len))
                    for (int i = 0; i < tv[k].len; i++) words.push_back($urandom);
            end
            run_load(tv[k].len, xor_all() ^ tv[k].csum_flip, tv[k].gap,
                     tv[k].exp_err, tv[k].exp_wl, $sformatf("v%0d", k));
        end

        // Asynchronous reset part-way through DATA, then a clean reload.
        case1_words();
        img.delete();
        push32(32'd2);
        push32(32'h00000013);
        img.push_back(8'h93);
        pulse_load();
        send(0, "midrst");
        check("midrst pre words_loaded0", words_loaded0, 32'd1);
        check("midrst pre busy0", 32'(busy0), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst core_reset0", 32'(core_reset0), 32'd1);
        check("midrst busy0", 32'(busy0), 32'd0);
        check("midrst rx_ready0", 32'(rx_ready0), 32'd0);
        check("midrst words_loaded0", words_loaded0, 32'd0);
        check("midrst mem_address0", 32'(mem_address0), 32'd0);
        check("midrst mem_address1", 32'(mem_address1), 32'(B1));
        check("midrst status0", 32'({start0, done0, error0, mem_write0}), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        run_load(32'd2, 32'h00100080, 0, 1'b0, 2, "after_rst");

        // Random images judged by the image rules alone.
        for (int r = 0; r < 10; r++) begin
            logic [31:0] n, cs;
            bit          e;
            n = ($urandom_range(5) == 0) ? 32'(1025 + $urandom_range(50)) : 32'($urandom_range(1, 24));
            words.delete();
            if (len_ok(n))
                for (int i = 0; i < n; i++) words.push_back($urandom);
            cs = xor_all();
            if ($urandom_range(99) < 30) cs ^= 32'h1 << $urandom_range(31);
            e = !len_ok(n) || cs != xor_all();
            run_load(n, cs, $urandom_range(60), e, len_ok(n) ? int'(n) : 0, $sformatf("r%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
